ag32gbd_cam_regs: RTL

- Camera register window of the cartridge: consumes the RAM-bank id from the SRAM banking stage and claims A000-BFFF when bank bit 4 is set (0x10-0x1F).
- Holds capture control, exposure/gain registers and the 48-byte dither matrix.
- Runs the capture handshake toward the sensor/conversion pipeline.
- Provides the cart read path for the busy bit and a sideband read port for the dither matrix.

---
 rtl/ag32gbd_pkg.sv | 26 ++
 rtl/ag32gbd_wr_strobe.sv | 26 ++
 rtl/ag32gbd_cam_regs.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ag32gbd_pkg.sv
// Shared constants and types for the ag32gbd camera register window.
package ag32gbd_pkg;

    localparam logic [6:0] CAM_REG_CTRL         = 7'h00;
    localparam logic [6:0] CAM_REG_GAIN         = 7'h01;
    localparam logic [6:0] CAM_REG_EXP_HI       = 7'h02;
    localparam logic [6:0] CAM_REG_EXP_LO       = 7'h03;
    localparam logic [6:0] CAM_REG_EDGE         = 7'h04;
    localparam logic [6:0] CAM_REG_VREF         = 7'h05;
    localparam logic [6:0] CAM_REG_DITHER_FIRST = 7'h06;
    localparam logic [6:0] CAM_REG_DITHER_LAST  = 7'h35;

    localparam int unsigned CAM_DITHER_BYTES =
        int'(CAM_REG_DITHER_LAST - CAM_REG_DITHER_FIRST) + 1;

    // Window decode: A000-BFFF, only for RAM banks with bit 4 set.
    localparam logic [2:0]  CAM_WIN_A_HI = 3'b101;
    localparam int unsigned CAM_BANK_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } cap_state_t;

endpackage

// File: rtl/ag32gbd_wr_strobe.sv
// Cart nWR history (resets to 2'b11) and falling-edge write pulse.
module ag32gbd_wr_strobe (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic nwr_i,
    output logic wr_pulse_c
);

    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb begin
        hist_d = {hist_q[0], nwr_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign wr_pulse_c = (hist_q == 2'b10);

endmodule

// File: rtl/ag32gbd_cam_regs.sv
// Camera register window, dither matrix and capture handshake FSM.
// Optional CAM_TIMEOUT_EN: aborts a stalled capture and sets read bit7 of A000.
module ag32gbd_cam_regs
    import ag32gbd_pkg::*;
#(
    parameter int unsigned DITHER_BYTES = CAM_DITHER_BYTES
`ifdef CAM_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
`endif
) (
    input  logic        sys_clock,
    input  logic        sys_resetn,
    input  logic [15:0] Cart_a,
    input  logic [7:0]  Cart_d,
    input  logic        Cart_nWR,
    input  logic        Cart_nRD,
    input  logic        Cart_nCS,
    input  logic [4:0]  Ram_Bank_Id,
    output logic        is_accessing_regs,
    output logic [7:0]  Reg_output,
    output logic        capture_req,
    input  logic        capture_ack,
    input  logic        capture_done,
    output logic        capture_busy,
    output logic [2:0]  cam_ctrl,
    output logic [7:0]  cam_gain,
    output logic [15:0] cam_exposure,
    output logic [7:0]  cam_edge,
    output logic [7:0]  cam_vref,
    input  logic [5:0]  dither_addr,
    output logic [7:0]  dither_data
);

    logic       wr_pulse_c;
    logic [6:0] offset_c;
    logic       wr_en_c;
    logic       trigger_c;
    logic       dither_hit_c;
    logic [5:0] dither_idx_c;
    logic       timeout_flag_c;
    logic       unused_ok;

    cap_state_t state_q, state_d;
    logic       req_d, busy_d;
    logic [1:0] ctrl_hi_q, ctrl_hi_d;
    logic [7:0] gain_q, gain_d, edge_q, edge_d, vref_q, vref_d;
    logic [15:0] exp_q, exp_d;
    logic [7:0] dither_q [DITHER_BYTES];
    logic [7:0] dither_d [DITHER_BYTES];
    logic [7:0] dither_data_d;

    ag32gbd_wr_strobe u_wr_strobe (
        .clk_i      (sys_clock),
        .rst_ni     (sys_resetn),
        .nwr_i      (Cart_nWR),
        .wr_pulse_c (wr_pulse_c)
    );

    // Window mirrors every 0x80 bytes, so only the low 7 address bits decode.
    assign offset_c          = Cart_a[6:0];
    assign is_accessing_regs = (Cart_a[15:13] == CAM_WIN_A_HI) && Ram_Bank_Id[CAM_BANK_BIT];
    assign wr_en_c           = wr_pulse_c && is_accessing_regs && !Cart_nCS;
    assign trigger_c         = wr_en_c && (offset_c == CAM_REG_CTRL) && Cart_d[0];
    assign dither_hit_c      = (offset_c >= CAM_REG_DITHER_FIRST) &&
                               (32'(offset_c) < 32'(CAM_REG_DITHER_FIRST) + DITHER_BYTES);
    assign dither_idx_c      = 6'(offset_c - CAM_REG_DITHER_FIRST);
    assign unused_ok         = ^{Cart_a[12:7], Ram_Bank_Id[3:0]};

    // Register file write decode.
    always_comb begin
        ctrl_hi_d = ctrl_hi_q;
        gain_d    = gain_q;
        exp_d     = exp_q;
        edge_d    = edge_q;
        vref_d    = vref_q;
        dither_d  = dither_q;
        if (wr_en_c) begin
            case (offset_c)
                CAM_REG_CTRL:   ctrl_hi_d   = Cart_d[2:1];
                CAM_REG_GAIN:   gain_d      = Cart_d;
                CAM_REG_EXP_HI: exp_d[15:8] = Cart_d;
                CAM_REG_EXP_LO: exp_d[7:0]  = Cart_d;
                CAM_REG_EDGE:   edge_d      = Cart_d;
                CAM_REG_VREF:   vref_d      = Cart_d;
                default: begin
                    if (dither_hit_c) begin
                        dither_d[dither_idx_c] = Cart_d;
                    end
                end
            endcase
        end
        dither_data_d = (32'(dither_addr) < DITHER_BYTES) ? dither_q[dither_addr] : 8'h00;
    end

`ifdef CAM_TIMEOUT_EN
    logic [23:0] cnt_q, cnt_d;
    logic        flag_q, flag_d;
`endif

    // Capture FSM next state; done wins over ack and over a coincident trigger.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (trigger_c) state_d = REQ;
            REQ: begin
                if (capture_done) begin
                    state_d = IDLE;
                end else if (capture_ack) begin
                    state_d = BUSY;
                end
            end
            BUSY: if (capture_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef CAM_TIMEOUT_EN
        flag_d = flag_q;
        cnt_d  = (state_q == IDLE) ? 24'd0 : cnt_q + 24'd1;
        if ((state_q != IDLE) && (cnt_q == TIMEOUT_CYCLES - 24'd1)) begin
            state_d = IDLE;
            flag_d  = 1'b1;
        end else if (trigger_c) begin
            flag_d = 1'b0;
        end
`endif
        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q      <= IDLE;
            capture_req  <= 1'b0;
            capture_busy <= 1'b0;
            ctrl_hi_q    <= 2'b00;
            gain_q       <= 8'h00;
            exp_q        <= 16'h0000;
            edge_q       <= 8'h00;
            vref_q       <= 8'h00;
            dither_q     <= '{default: 8'h00};
            dither_data  <= 8'h00;
`ifdef CAM_TIMEOUT_EN
            cnt_q        <= 24'd0;
            flag_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            capture_req  <= req_d;
            capture_busy <= busy_d;
            ctrl_hi_q    <= ctrl_hi_d;
            gain_q       <= gain_d;
            exp_q        <= exp_d;
            edge_q       <= edge_d;
            vref_q       <= vref_d;
            dither_q     <= dither_d;
            dither_data  <= dither_data_d;
`ifdef CAM_TIMEOUT_EN
            cnt_q        <= cnt_d;
            flag_q       <= flag_d;
`endif
        end
    end

`ifdef CAM_TIMEOUT_EN
    assign timeout_flag_c = flag_q;
`else
    assign timeout_flag_c = 1'b0;
`endif

    // Only A000 is readable; everything else in the window is write-only.
    always_comb begin
        Reg_output = 8'h00;
        if (is_accessing_regs && !Cart_nCS && !Cart_nRD && (offset_c == CAM_REG_CTRL)) begin
            Reg_output = {timeout_flag_c, 4'b0000, ctrl_hi_q, capture_busy};
        end
    end

    assign cam_ctrl     = {ctrl_hi_q, capture_busy};
    assign cam_gain     = gain_q;
    assign cam_exposure = exp_q;
    assign cam_edge     = edge_q;
    assign cam_vref     = vref_q;

endmodule
